// File: rtl/seu_pkg.sv
// Shared definitions for the SEU ROM read-back scrubber: scan states,
// default geometry and the golden-value rule used by ROM init and checkers.
package seu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } seu_state_t;

  localparam int SEU_ADDR_W = 4;
  localparam int SEU_DATA_W = 8;

  // Golden content: every word holds its own address.
  function automatic logic [31:0] seu_expected(input logic [31:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/seu_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seu_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seu_rom_scanner.sv
// Sweeps the SEU test ROM, compares each registered read-back word with its
// golden value and records mismatch statistics for the control logic.
module seu_rom_scanner
  import seu_pkg::*;
#(
  parameter int ADDR_W = SEU_ADDR_W,
  parameter int DATA_W = SEU_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              clear,
  output logic              rom_read,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic [DATA_W-1:0] last_err_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  seu_state_t        state, state_next;
  logic              cont_mode;
  logic              stop_seen;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_SCAN;
      ST_SCAN:  if (rom_addr == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: state_next = (cont_mode && !stop_seen && !stop) ? ST_SCAN : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rom_read  <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cont_mode <= 1'b0;
      stop_seen <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
    end else begin
      state    <= state_next;
      rom_read <= (state_next == ST_SCAN);
      rom_addr <= (state == ST_SCAN && state_next == ST_SCAN) ? rom_addr + 1'b1 : '0;
      busy     <= (state_next != ST_IDLE);
      done     <= (state == ST_DRAIN) && (state_next == ST_IDLE);
      // A stop arriving with start in IDLE degrades the request to one pass.
      if (state == ST_IDLE && start) begin
        cont_mode <= continuous && !stop;
        stop_seen <= 1'b0;
      end else if (state != ST_IDLE && stop) begin
        stop_seen <= 1'b1;
      end
      cmp_valid <= rom_read;
      cmp_addr  <= rom_addr;
    end
  end

  assign expected = DATA_W'(seu_expected(32'(cmp_addr)));
  assign mismatch = cmp_valid && (rom_data != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt      <= '0;
      err_flag      <= 1'b0;
      last_err_addr <= '0;
      last_err_data <= '0;
    end else if (clear) begin
      pass_cnt      <= '0;
      err_flag      <= 1'b0;
      last_err_addr <= '0;
      last_err_data <= '0;
    end else begin
      if (state == ST_DRAIN) pass_cnt <= pass_cnt + 1'b1;
      if (mismatch) begin
        err_flag      <= 1'b1;
        last_err_addr <= cmp_addr;
        last_err_data <= rom_data;
      end
    end
  end

  seu_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch),
    .clr   (clear),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_seu_rom_scanner.sv
// Bench for seu_rom_scanner: two instances (16-bit and 2-bit counters) each
// reading a registered ROM model, checked against a per-pass scoreboard.
module tb_seu_rom_scanner;
  import seu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, continuous = 1'b0, stop = 1'b0, clear = 1'b0;

  logic        rd1, busy1, done1, flag1;
  logic [3:0]  addr1, laddr1;
  logic [7:0]  data1 = 8'h00, ldata1;
  logic [15:0] err1, pass1;

  logic        rd2, busy2, done2, flag2;
  logic [3:0]  addr2, laddr2;
  logic [7:0]  data2 = 8'h00, ldata2;
  logic [1:0]  err2, pass2;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];

  int total = 0;
  int bad = 0;

  int m_err, m_pass, m_flag, m_laddr, m_ldata;
  int addr_log[$];
  int done_pulses, read_leak, cycles;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd1) data1 <= mem1[addr1];
  always @(posedge clk) if (rd2) data2 <= mem2[addr2];

  seu_rom_scanner #(.ADDR_W(4), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .clear(clear), .rom_read(rd1), .rom_addr(addr1), .rom_data(data1),
    .busy(busy1), .done(done1), .err_flag(flag1), .err_cnt(err1),
    .pass_cnt(pass1), .last_err_addr(laddr1), .last_err_data(ldata1)
  );

  seu_rom_scanner #(.ADDR_W(4), .DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .clear(clear), .rom_read(rd2), .rom_addr(addr2), .rom_data(data2),
    .busy(busy2), .done(done2), .err_flag(flag2), .err_cnt(err2),
    .pass_cnt(pass2), .last_err_addr(laddr2), .last_err_data(ldata2)
  );

  task automatic load_golden();
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 8'(seu_expected(32'(i)));
      mem2[i] = 8'(seu_expected(32'(i)));
    end
  endtask

  task automatic model_clear();
    m_err = 0; m_pass = 0; m_flag = 0; m_laddr = 0; m_ldata = 0;
  endtask

  // Scoreboard: one full pass over mem1, golden word i equals i.
  task automatic model_pass();
    for (int i = 0; i < 16; i++) begin
      if (int'(mem1[i]) != i) begin
        if (m_err < 65535) m_err++;
        m_flag = 1; m_laddr = i; m_ldata = int'(mem1[i]);
      end
    end
    m_pass = (m_pass + 1) % 65536;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  // Launches a scan and waits for done; k counts negedges after the start edge.
  task automatic run(input bit cont, input int stop_at, input int start_at,
                     input int clear_at, input string tag);
    addr_log.delete(); done_pulses = 0; read_leak = 0; cycles = 0;
    @(negedge clk); start = 1'b1; continuous = cont;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == start_at); stop = (k == stop_at); clear = (k == clear_at);
      if (rd1) addr_log.push_back(int'(addr1));
      if (rd1 && !busy1) read_leak++;
      if (done1) begin done_pulses++; cycles = k; break; end
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; continuous = 1'b0;
    if (cycles == 0) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_done want=done", tag);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_width got done=%0b busy=%0b want 0 0", tag, done1, busy1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({rd1, addr1, busy1, done1, flag1, err1, pass1, laddr1, ldata1} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rd=%0b addr=%0d busy=%0b done=%0b flag=%0b err=%0d pass=%0d la=%0d ld=%0h want all 0",
               rd1, addr1, busy1, done1, flag1, err1, pass1, laddr1, ldata1);
    end
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    $display("test_reset: checked");
  endtask

  task automatic test_clean();
    load_golden();
    run(1'b0, 0, 0, 0, "clean");
    model_pass();
    total++;
    if (cycles != 18) begin bad++; $display("FAIL clean_latency got=%0d want=18", cycles); end
    total++;
    if (addr_log.size() != 16) begin
      bad++; $display("FAIL clean_read_count got=%0d want=16", addr_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (addr_log[i] != i) begin bad++; $display("FAIL clean_addr got=%0d want=%0d", addr_log[i], i); end
      end
    end
    total++;
    if (err1 !== 16'(m_err) || flag1 !== 1'(m_flag) || pass1 !== 16'(m_pass)) begin
      bad++;
      $display("FAIL clean_status got err=%0d flag=%0b pass=%0d want err=%0d flag=%0d pass=%0d",
               err1, flag1, pass1, m_err, m_flag, m_pass);
    end
    total++;
    if (read_leak != 0) begin bad++; $display("FAIL clean_read_leak got=%0d want=0", read_leak); end
    $display("test_clean: cycles=%0d err=%0d pass=%0d", cycles, err1, pass1);
  endtask

  task automatic test_single_fault();
    pulse_clear();
    load_golden();
    mem1[5] = 8'h25;
    run(1'b0, 0, 0, 0, "fault");
    model_pass();
    total++;
    if (err1 !== 16'(m_err) || laddr1 !== 4'(m_laddr) || ldata1 !== 8'(m_ldata) || flag1 !== 1'(m_flag)) begin
      bad++;
      $display("FAIL fault_capture got err=%0d la=%0d ld=%0h flag=%0b want err=%0d la=%0d ld=%0h flag=%0d",
               err1, laddr1, ldata1, flag1, m_err, m_laddr, m_ldata, m_flag);
    end
    $display("test_single_fault: err=%0d addr=%0d data=%0h", err1, laddr1, ldata1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      load_golden();
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 3) == 0) mem1[i] = 8'($urandom);
      run(1'b0, 0, 0, 0, "random");
      model_pass();
      total++;
      if (err1 !== 16'(m_err) || pass1 !== 16'(m_pass) || flag1 !== 1'(m_flag) ||
          laddr1 !== 4'(m_laddr) || ldata1 !== 8'(m_ldata)) begin
        bad++;
        $display("FAIL random_pass%0d got err=%0d pass=%0d flag=%0b la=%0d ld=%0h want err=%0d pass=%0d flag=%0d la=%0d ld=%0h",
                 r, err1, pass1, flag1, laddr1, ldata1, m_err, m_pass, m_flag, m_laddr, m_ldata);
      end
      $display("test_random[%0d]: err=%0d pass=%0d", r, err1, pass1);
    end
  endtask

  task automatic test_continuous();
    pulse_clear();
    load_golden();
    mem1[9] = 8'hA9;
    run(1'b1, 40, 0, 0, "cont");
    for (int p = 0; p < 3; p++) model_pass();
    total++;
    if (pass1 !== 16'(m_pass) || err1 !== 16'(m_err)) begin
      bad++; $display("FAIL cont_counts got pass=%0d err=%0d want pass=%0d err=%0d", pass1, err1, m_pass, m_err);
    end
    total++;
    if (cycles != 52 || done_pulses != 1) begin
      bad++; $display("FAIL cont_timing got cycles=%0d done=%0d want cycles=52 done=1", cycles, done_pulses);
    end
    total++;
    if (addr_log.size() != 48) begin
      bad++; $display("FAIL cont_reads got=%0d want=48", addr_log.size());
    end else begin
      for (int i = 0; i < 48; i++) begin
        total++;
        if (addr_log[i] != i % 16) begin bad++; $display("FAIL cont_addr got=%0d want=%0d", addr_log[i], i % 16); end
      end
    end
    $display("test_continuous: cycles=%0d pass=%0d err=%0d", cycles, pass1, err1);
  endtask

  task automatic test_control_edges();
    pulse_clear();
    load_golden();
    run(1'b0, 0, 6, 0, "midstart");
    total++;
    if (cycles != 18 || addr_log.size() != 16) begin
      bad++; $display("FAIL midstart_length got cycles=%0d reads=%0d want 18 16", cycles, addr_log.size());
    end
    // Word 3 is compared at E5, the same edge that samples clear.
    pulse_clear();
    mem1[3] = 8'h77;
    run(1'b0, 0, 0, 5, "clrhit");
    total++;
    if (err1 !== 16'd0 || flag1 !== 1'b0 || laddr1 !== 4'd0 || ldata1 !== 8'd0 || pass1 !== 16'd1) begin
      bad++;
      $display("FAIL clear_priority got err=%0d flag=%0b la=%0d ld=%0h pass=%0d want 0 0 0 0 1",
               err1, flag1, laddr1, ldata1, pass1);
    end
    $display("test_control_edges: midstart cycles=%0d clear err=%0d", cycles, err1);
  endtask

  task automatic test_saturation();
    int mism;
    pulse_clear();
    load_golden();
    mism = 0;
    for (int i = 0; i < 16; i++) begin
      mem2[i] = ~8'(i);
      if (int'(mem2[i]) != i) mism++;
    end
    run(1'b0, 0, 0, 0, "sat");
    total++;
    if (err2 !== 2'((mism > 3) ? 3 : mism) || laddr2 !== 4'd15 || ldata2 !== 8'hF0 || flag2 !== 1'b1) begin
      bad++;
      $display("FAIL sat_counter got err=%0d la=%0d ld=%0h flag=%0b want err=3 la=15 ld=f0 flag=1",
               err2, laddr2, ldata2, flag2);
    end
    $display("test_saturation: err=%0d la=%0d ld=%0h", err2, laddr2, ldata2);
  endtask

  task automatic test_reset_mid();
    bit hit;
    pulse_clear();
    load_golden();
    mem1[2] = 8'h00;
    hit = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (rd1 && addr1 == 4'd7) hit = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rstmid_reach got=no_addr7 want=addr7"); end
    rst = 1'b1;
    #1;
    total++;
    if ({rd1, addr1, busy1, done1, flag1, err1, pass1, laddr1, ldata1} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got rd=%0b addr=%0d busy=%0b flag=%0b err=%0d pass=%0d want all 0",
               rd1, addr1, busy1, flag1, err1, pass1);
    end
    @(negedge clk); rst = 1'b0;
    model_clear();
    load_golden();
    run(1'b0, 0, 0, 0, "rstmid");
    model_pass();
    total++;
    if (pass1 !== 16'(m_pass) || err1 !== 16'(m_err) || cycles != 18) begin
      bad++; $display("FAIL rstmid_rerun got pass=%0d err=%0d cycles=%0d want pass=%0d err=%0d cycles=18",
                      pass1, err1, cycles, m_pass, m_err);
    end
    $display("test_reset_mid: pass=%0d err=%0d", pass1, err1);
  endtask

  initial begin
    load_golden();
    test_reset();
    test_clean();
    test_single_fault();
    test_random();
    test_continuous();
    test_control_edges();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seu_rom_scanner.md
# seu_rom_scanner

Read-back scrubber that sits directly upstream and downstream of the 16×8 SEU test ROM. It sweeps every ROM address by driving the ROM's `read`/`addr` inputs, and consumes the registered ROM output one cycle later. Each word is compared against its golden value, word *i* = *i*. Mismatches are counted, and the last failing address/data is latched for readout by the SEU-test control logic.

## Interface
Parameters:
- `ADDR_W`, 4: ROM address width; depth = 2^ADDR_W.
- `DATA_W`, 8: ROM data width; must be ≥ ADDR_W.
- `CNT_W`, 16: width of the error and pass counters.

Ports:
- `clk`  in  1  — single clock, rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — begin a scan; sampled in IDLE only.
- `continuous`  in  1  — sampled with `start`; 1 = repeat passes until `stop`.
- `stop`  in  1  — end continuous mode after the current pass completes.
- `clear`  in  1  — synchronous clear of `err_cnt`, `pass_cnt`, `err_flag`, `last_err_*`.
- `rom_read`  out  1  — to ROM `read`.
- `rom_addr`  out  ADDR_W  — to ROM `addr`.
- `rom_data`  in  DATA_W  — from ROM `out`; valid one clock after `rom_read`.
- `busy`  out  1  — scan in progress.
- `done`  out  1  — one-cycle pulse when the final pass completes.
- `err_flag`  out  1  — sticky; set on any mismatch.
- `err_cnt`  out  CNT_W  — saturating mismatch count.
- `pass_cnt`  out  CNT_W  — completed passes; wraps.
- `last_err_addr`  out  ADDR_W  — address of the most recent mismatch.
- `last_err_data`  out  DATA_W  — data read at the most recent mismatch.

## Operation
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on `start`.
  - SCAN → DRAIN after address 2^ADDR_W−1 has been issued.
  - DRAIN → SCAN if the latched continuous bit is set and `stop` has not been seen; otherwise DRAIN → IDLE.
- SCAN: `rom_read`=1; `rom_addr` increments by 1 each cycle, starting at 0.
- Compare pipeline:
  - `cmp_valid`/`cmp_addr` register the issued read for one cycle.
  - When `cmp_valid`=1, `rom_data` is compared with the expected value, which is `cmp_addr` zero-extended to DATA_W.
- On mismatch:
  - `err_cnt` increments, saturating at 2^CNT_W−1.
  - `err_flag` is set.
  - `last_err_addr` and `last_err_data` are overwritten.
- `pass_cnt` increments on every DRAIN cycle.
- `stop` is latched while busy; the current pass always completes, so a stop never truncates a pass.
- `start` while busy is ignored. `start` together with `stop` in IDLE gives a single pass.
- `clear` has priority over a same-cycle increment or capture, and is legal in any state.
- `rst` mid-scan: immediate return to IDLE with every output at its reset value; the partial pass is not counted.

## Timing
- Reset values: all outputs 0, including `rom_addr`=0 and `rom_read`=0.
- All outputs are registered.
- Single pass, with `start` sampled at edge E0:
  - `rom_read`=1 and `rom_addr`=0 from E0.
  - The ROM samples address *i* at E(i+1); that word is compared at E(i+2).
  - Address 15 is driven E15–E16; the last compare is at E17.
  - `busy` is high E0–E17.
  - `done` is high for exactly one cycle, E17–E18.
  - `err_cnt` is final when `done` is seen.
- Continuous mode: one DRAIN cycle separates passes, so each pass is 2^ADDR_W+1 cycles. `done` pulses only at the final pass.
- `rom_read` is never high outside SCAN.

## Structure
- Shared package `seu_pkg` holds:
  - the state enum;
  - the default `ADDR_W`/`DATA_W`;
  - a golden-value function `seu_expected(addr)`, which is shared with the ROM initialisation and the bench model.
- One sub-module: `seu_sat_counter`, a CNT_W saturating counter with `inc`/`clr`, instantiated for `err_cnt`. `pass_cnt` is an inline wrapping counter.

## Test plan
- Clean pass: golden ROM, pulse `start` → 16 reads at addresses 0..15; `done` at E17; `err_cnt`=0; `err_flag`=0; `pass_cnt`=1.
- Single fault: bench ROM word 5 = 0x25 → `err_cnt`=1, `last_err_addr`=5, `last_err_data`=0x25, `err_flag`=1.
- Continuous: `start` with `continuous`=1, assert `stop` during pass 3 → `pass_cnt`=3; one `done` pulse at the end of pass 3; no truncated pass.
- Saturation: CNT_W=2, all words inverted → `err_cnt` holds 3; `last_err_addr`=15; `last_err_data`=0xF0.
- Control edges:
  - `start` mid-scan is ignored, with the pass length unchanged.
  - `clear` coincident with a mismatch leaves `err_cnt`=0.
- Reset mid-scan: assert `rst` at address 7 → all outputs 0 and `rom_read`=0 immediately. A following clean `start` gives `pass_cnt`=1 and `err_cnt`=0.
